hps_reset_sequencer: RTL and testbench
======================================

// Module: hps_reset_sequencer
// PURPOSE
//  Sequences FPGA-to-HPS reset requests (cold, warm, debug) for the soc_system HPS.
//  - Turns fabric request edges (debounced keys, debug logic) into fixed-width active-low pulses.
//  - Cold and warm requests then wait for the HPS to acknowledge through h2f_reset_n, with a timeout.
//  - A holdoff window follows before the next request is accepted.
//  - Sits between fabric request sources and the hps_0_f2h_*_reset_req_reset_n inputs.
// PARAMETERS
//  PULSE_CYCLES    16          width of each req_n low pulse, in clk_clk cycles (>=1)
//  ACK_TIMEOUT     50000000    max cycles spent in WAIT_ACK_LO + WAIT_ACK_HI combined
//  HOLDOFF_CYCLES  1024        idle gap after each sequence (>=1)
//  CNT_W           26          shared counter width; must hold max(all three counts)
// PORTS
//  clk_clk          in   1  system clock
//  reset_reset      in   1  synchronous, active-high reset
//  cold_req         in   1  request level; its rising edge requests a cold reset
//  warm_req         in   1  request level; its rising edge requests a warm reset
//  debug_req        in   1  request level; its rising edge requests a debug reset
//  h2f_reset_n      in   1  HPS fabric reset (asynchronous); 2-flop synchronised internally
//  clr_err          in   1  clears timeout_err
//  f2h_cold_req_n   out  1  to hps_0_f2h_cold_reset_req_reset_n
//  f2h_warm_req_n   out  1  to hps_0_f2h_warm_reset_req_reset_n
//  f2h_debug_req_n  out  1  to hps_0_f2h_debug_reset_req_reset_n
//  busy             out  1  high whenever state != IDLE
//  last_type        out  2  last type served: 0 none, 1 debug, 2 warm, 3 cold
//  timeout_err      out  1  sticky: acknowledge timed out
// BEHAVIOUR
//  - Reset: state IDLE; all req_n = 1; busy = 0; last_type = 0; timeout_err = 0.
//  - Reset also clears pending bits and counters.
//  - Reset sets the edge-detect prev registers to 1: a level held high through reset release does not fire.
//  - Edge detect: rise_x = x_req & ~prev_x. Each rise sets pending_x, in any state.
//  - Priority: cold > warm > debug.
//  - IDLE: if any pending bit (or rise this cycle) is set, go to ASSERT with the highest-priority type.
//    - Set last_type on this transition.
//    - Clear pending of that type and of every lower-priority type (a cold clears all).
//  - ASSERT: the selected req_n is low for exactly PULSE_CYCLES cycles.
//    - The pulse starts the cycle after the rise is seen.
//    - Outputs are registered and only one req_n is low at a time.
//    - Debug type: go to HOLDOFF; no acknowledge wait.
//    - Cold/warm type: go to WAIT_ACK_LO and clear the timeout counter.
//  - WAIT_ACK_LO: synchronised h2f_reset_n == 0 -> WAIT_ACK_HI.
//  - WAIT_ACK_HI: synchronised h2f_reset_n == 1 -> HOLDOFF.
//  - Timeout: one counter runs across both wait states.
//    - At ACK_TIMEOUT, set timeout_err and go to HOLDOFF.
//  - HOLDOFF: count HOLDOFF_CYCLES, then go to IDLE.
//    - Pending requests are serviced from IDLE on the next cycle.
//  - Requests that arrive while busy are latched as pending, never dropped.
//    - Repeated rises of the same type collapse into one.
//  - clr_err and a timeout in the same cycle: the set wins.
//  - reset_reset mid-sequence: all req_n return to 1 on the next edge. An in-flight pulse may be truncated.
// TESTING (PULSE_CYCLES=4, ACK_TIMEOUT=20, HOLDOFF_CYCLES=8)
//  1. warm_req rises at cycle 10; model pulls h2f_reset_n low at 17-21.
//     -> f2h_warm_req_n low exactly cycles 11-14; last_type=2; busy falls 8 cycles after ack; timeout_err=0.
//  2. debug_req rises -> f2h_debug_req_n low 4 cycles, no ack wait, busy high 12 cycles total; last_type=1.
//  3. cold_req and debug_req rise in the same cycle -> only cold pulses; debug pending is cleared;
//     no debug pulse follows.
//  4. warm_req rises, h2f_reset_n held high -> timeout_err=1 after 20 wait cycles.
//     -> Then HOLDOFF, then IDLE. clr_err pulse -> timeout_err=0.
//  5. debug_req rises during a warm WAIT_ACK_HI -> debug pulse starts 1 cycle after warm's HOLDOFF ends.
//     A cold_req rise during that debug pulse -> a cold pulse follows after the next HOLDOFF.
//  6. reset_reset asserted on ASSERT cycle 2 -> req_n = 1 and busy = 0 next cycle.
//     warm_req held high across reset release -> no new pulse.

Source files
------------

// File: rtl/hps_reset_sequencer.sv
// Turns fabric reset-request edges into fixed-width active-low pulses to the HPS.
// Cold and warm requests wait for the HPS to acknowledge; a holdoff gap follows each sequence.
module hps_reset_sequencer #(
  parameter int PULSE_CYCLES   = 16,
  parameter int ACK_TIMEOUT    = 50000000,
  parameter int HOLDOFF_CYCLES = 1024,
  parameter int CNT_W          = 26
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       cold_req,
  input  logic       warm_req,
  input  logic       debug_req,
  input  logic       h2f_reset_n,
  input  logic       clr_err,
  output logic       f2h_cold_req_n,
  output logic       f2h_warm_req_n,
  output logic       f2h_debug_req_n,
  output logic       busy,
  output logic [1:0] last_type,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    ASSERT,
    WAIT_ACK_LO,
    WAIT_ACK_HI,
    HOLDOFF
  } state_t;

  localparam logic [1:0] TYPE_DEBUG = 2'd1;
  localparam logic [1:0] TYPE_WARM  = 2'd2;
  localparam logic [1:0] TYPE_COLD  = 2'd3;

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLDOFF_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       type_nxt;
  logic [2:0]       prev, rise, pending, pending_nxt, eff;
  logic [2:0]       req_n_nxt;
  logic [1:0]       h2f_sync;
  logic             ack_lo;
  logic             err_set;

  // Bit order for request vectors: [2] cold, [1] warm, [0] debug.
  assign rise   = {cold_req, warm_req, debug_req} & ~prev;
  assign eff    = pending | rise;
  assign ack_lo = ~h2f_sync[1];
  assign busy   = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CNT_W'(1);
    type_nxt    = last_type;
    pending_nxt = eff;
    err_set     = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (eff != 3'b000) begin
          state_nxt   = ASSERT;
          // Selected type plus all lower ones are cleared; higher ones are zero by priority.
          pending_nxt = 3'b000;
          if (eff[2])      type_nxt = TYPE_COLD;
          else if (eff[1]) type_nxt = TYPE_WARM;
          else             type_nxt = TYPE_DEBUG;
        end
      end
      ASSERT: begin
        if (cnt == PULSE_LAST) begin
          cnt_nxt   = '0;
          state_nxt = (last_type == TYPE_DEBUG) ? HOLDOFF : WAIT_ACK_LO;
        end
      end
      WAIT_ACK_LO: begin
        if (ack_lo) begin
          state_nxt = WAIT_ACK_HI;
        end else if (cnt >= TIMEOUT_LAST) begin
          err_set   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = HOLDOFF;
        end
      end
      WAIT_ACK_HI: begin
        if (!ack_lo) begin
          cnt_nxt   = '0;
          state_nxt = HOLDOFF;
        end else if (cnt >= TIMEOUT_LAST) begin
          err_set   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (cnt == HOLD_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase

    // Pulse outputs follow the next state so they are low exactly while ASSERT is held.
    req_n_nxt = 3'b111;
    if (state_nxt == ASSERT) begin
      case (type_nxt)
        TYPE_COLD:  req_n_nxt = 3'b011;
        TYPE_WARM:  req_n_nxt = 3'b101;
        TYPE_DEBUG: req_n_nxt = 3'b110;
        default:    req_n_nxt = 3'b111;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state           <= IDLE;
      cnt             <= '0;
      last_type       <= 2'd0;
      pending         <= 3'b000;
      prev            <= 3'b111;
      h2f_sync        <= 2'b11;
      timeout_err     <= 1'b0;
      f2h_cold_req_n  <= 1'b1;
      f2h_warm_req_n  <= 1'b1;
      f2h_debug_req_n <= 1'b1;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      last_type       <= type_nxt;
      pending         <= pending_nxt;
      prev            <= {cold_req, warm_req, debug_req};
      h2f_sync        <= {h2f_sync[0], h2f_reset_n};
      f2h_cold_req_n  <= req_n_nxt[2];
      f2h_warm_req_n  <= req_n_nxt[1];
      f2h_debug_req_n <= req_n_nxt[0];
      if (err_set)      timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hps_reset_sequencer.sv
// Directed bench for hps_reset_sequencer with short pulse/timeout/holdoff parameters.
// Inputs change 1ns after a rising edge; outputs are sampled at that same point.
module tb_hps_reset_sequencer;

  logic       clk_clk = 1'b0;
  logic       reset_reset;
  logic       cold_req, warm_req, debug_req;
  logic       h2f_reset_n;
  logic       clr_err;
  logic       f2h_cold_req_n, f2h_warm_req_n, f2h_debug_req_n;
  logic       busy;
  logic [1:0] last_type;
  logic       timeout_err;

  int checks   = 0;
  int failures = 0;

  hps_reset_sequencer #(
    .PULSE_CYCLES  (4),
    .ACK_TIMEOUT   (20),
    .HOLDOFF_CYCLES(8),
    .CNT_W         (26)
  ) dut (
    .clk_clk        (clk_clk),
    .reset_reset    (reset_reset),
    .cold_req       (cold_req),
    .warm_req       (warm_req),
    .debug_req      (debug_req),
    .h2f_reset_n    (h2f_reset_n),
    .clr_err        (clr_err),
    .f2h_cold_req_n (f2h_cold_req_n),
    .f2h_warm_req_n (f2h_warm_req_n),
    .f2h_debug_req_n(f2h_debug_req_n),
    .busy           (busy),
    .last_type      (last_type),
    .timeout_err    (timeout_err)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  initial begin
    reset_reset = 1'b1;
    cold_req    = 1'b0;
    warm_req    = 1'b0;
    debug_req   = 1'b0;
    h2f_reset_n = 1'b1;
    clr_err     = 1'b0;
    applyStimulus(3);
    checkOutput("rst_cold_n", 32'(f2h_cold_req_n), 32'd1);
    checkOutput("rst_warm_n", 32'(f2h_warm_req_n), 32'd1);
    checkOutput("rst_debug_n", 32'(f2h_debug_req_n), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_last_type", 32'(last_type), 32'd0);
    checkOutput("rst_err", 32'(timeout_err), 32'd0);
    reset_reset = 1'b0;
    applyStimulus(2);

    // Warm request with an HPS acknowledge pulse.
    $display("[TB] warm with ack");
    warm_req = 1'b1;
    applyStimulus(1);
    checkOutput("w_pulse_start", 32'(f2h_warm_req_n), 32'd0);
    checkOutput("w_last_type", 32'(last_type), 32'd2);
    checkOutput("w_busy", 32'(busy), 32'd1);
    checkOutput("w_cold_idle", 32'(f2h_cold_req_n), 32'd1);
    applyStimulus(3);
    checkOutput("w_pulse_last", 32'(f2h_warm_req_n), 32'd0);
    applyStimulus(1);
    checkOutput("w_pulse_end", 32'(f2h_warm_req_n), 32'd1);
    checkOutput("w_busy_wait", 32'(busy), 32'd1);
    warm_req = 1'b0;
    applyStimulus(2);
    h2f_reset_n = 1'b0;
    applyStimulus(5);
    h2f_reset_n = 1'b1;
    applyStimulus(10);
    checkOutput("w_busy_holdoff", 32'(busy), 32'd1);
    applyStimulus(1);
    checkOutput("w_busy_done", 32'(busy), 32'd0);
    checkOutput("w_err", 32'(timeout_err), 32'd0);

    // Debug request: no acknowledge wait.
    $display("[TB] debug");
    debug_req = 1'b1;
    applyStimulus(1);
    checkOutput("d_pulse_start", 32'(f2h_debug_req_n), 32'd0);
    checkOutput("d_last_type", 32'(last_type), 32'd1);
    checkOutput("d_warm_idle", 32'(f2h_warm_req_n), 32'd1);
    applyStimulus(3);
    checkOutput("d_pulse_last", 32'(f2h_debug_req_n), 32'd0);
    applyStimulus(1);
    checkOutput("d_pulse_end", 32'(f2h_debug_req_n), 32'd1);
    debug_req = 1'b0;
    applyStimulus(7);
    checkOutput("d_busy_12", 32'(busy), 32'd1);
    applyStimulus(1);
    checkOutput("d_busy_done", 32'(busy), 32'd0);

    // Simultaneous cold and debug: cold wins and the debug request is discarded.
    $display("[TB] cold+debug");
    cold_req  = 1'b1;
    debug_req = 1'b1;
    applyStimulus(1);
    checkOutput("cd_cold_low", 32'(f2h_cold_req_n), 32'd0);
    checkOutput("cd_debug_high", 32'(f2h_debug_req_n), 32'd1);
    checkOutput("cd_last_type", 32'(last_type), 32'd3);
    cold_req  = 1'b0;
    debug_req = 1'b0;
    applyStimulus(4);
    checkOutput("cd_cold_end", 32'(f2h_cold_req_n), 32'd1);
    h2f_reset_n = 1'b0;
    applyStimulus(3);
    h2f_reset_n = 1'b1;
    applyStimulus(11);
    checkOutput("cd_idle", 32'(busy), 32'd0);
    applyStimulus(2);
    checkOutput("cd_no_debug", 32'(f2h_debug_req_n), 32'd1);
    checkOutput("cd_still_idle", 32'(busy), 32'd0);

    // Warm request with no acknowledge: timeout, holdoff, then clear.
    $display("[TB] warm timeout");
    warm_req = 1'b1;
    applyStimulus(1);
    checkOutput("t_pulse", 32'(f2h_warm_req_n), 32'd0);
    warm_req = 1'b0;
    applyStimulus(23);
    checkOutput("t_err_before", 32'(timeout_err), 32'd0);
    checkOutput("t_busy_wait", 32'(busy), 32'd1);
    applyStimulus(1);
    checkOutput("t_err_set", 32'(timeout_err), 32'd1);
    applyStimulus(7);
    checkOutput("t_busy_holdoff", 32'(busy), 32'd1);
    applyStimulus(1);
    checkOutput("t_busy_done", 32'(busy), 32'd0);
    checkOutput("t_err_sticky", 32'(timeout_err), 32'd1);
    clr_err = 1'b1;
    applyStimulus(1);
    clr_err = 1'b0;
    checkOutput("t_err_cleared", 32'(timeout_err), 32'd0);

    // Requests arriving while busy are queued and served after holdoff.
    $display("[TB] queued requests");
    warm_req = 1'b1;
    applyStimulus(1);
    checkOutput("q_warm_pulse", 32'(f2h_warm_req_n), 32'd0);
    warm_req = 1'b0;
    applyStimulus(4);
    h2f_reset_n = 1'b0;
    applyStimulus(3);
    h2f_reset_n = 1'b1;
    debug_req   = 1'b1;
    applyStimulus(1);
    debug_req = 1'b0;
    checkOutput("q_debug_waits", 32'(f2h_debug_req_n), 32'd1);
    checkOutput("q_busy", 32'(busy), 32'd1);
    applyStimulus(10);
    checkOutput("q_idle_gap", 32'(busy), 32'd0);
    checkOutput("q_idle_debug_n", 32'(f2h_debug_req_n), 32'd1);
    applyStimulus(1);
    checkOutput("q_debug_pulse", 32'(f2h_debug_req_n), 32'd0);
    checkOutput("q_debug_type", 32'(last_type), 32'd1);
    applyStimulus(1);
    cold_req = 1'b1;
    applyStimulus(1);
    cold_req = 1'b0;
    applyStimulus(10);
    checkOutput("q_cold_waits", 32'(f2h_cold_req_n), 32'd1);
    checkOutput("q_idle_gap2", 32'(busy), 32'd0);
    applyStimulus(1);
    checkOutput("q_cold_pulse", 32'(f2h_cold_req_n), 32'd0);
    checkOutput("q_cold_type", 32'(last_type), 32'd3);

    // Reset during the pulse; a level held through reset release must not fire.
    $display("[TB] mid-sequence reset");
    applyStimulus(1);
    checkOutput("r_pulse_c2", 32'(f2h_cold_req_n), 32'd0);
    reset_reset = 1'b1;
    warm_req    = 1'b1;
    applyStimulus(1);
    checkOutput("r_cold_n", 32'(f2h_cold_req_n), 32'd1);
    checkOutput("r_busy", 32'(busy), 32'd0);
    checkOutput("r_last_type", 32'(last_type), 32'd0);
    reset_reset = 1'b0;
    applyStimulus(6);
    checkOutput("r_held_warm_n", 32'(f2h_warm_req_n), 32'd1);
    checkOutput("r_held_busy", 32'(busy), 32'd0);
    warm_req = 1'b0;
    applyStimulus(1);
    warm_req = 1'b1;
    applyStimulus(1);
    checkOutput("r_new_rise", 32'(f2h_warm_req_n), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
